ixc_assign_arb_38: RTL and testbench
====================================

# ixc_assign_arb_38

Round-robin arbiter and output register that shares one 38-bit assign datapath (the `ixc_assign` bit-slice array) between up to four requesters. Requesters present 38-bit beats with valid/ready handshakes and may lock the path for multi-beat bursts terminated by a last flag. The block registers the winning beat and drives the shared `R` bus of the downstream assign template with a source tag, so the shared slice array always sees exactly one owner.

## Interface

Parameters:
- `NREQ`, 4: number of requesters, range 2..4; source tag is 2 bits regardless.
- `W`, 38: datapath width; must match the downstream assign template width.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester beat valid.
- `req_data`  in  NREQ*W  requester i occupies bits [i*W +: W].
- `req_last`  in  NREQ  beat is final beat of burst; single-beat transfer has `req_last`=1.
- `req_ready`  out  NREQ  per-requester accept; at most one bit set in any cycle.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  W  registered beat; drives the shared assign datapath `R`.
- `out_src`  out  2  index of the requester that owns `out_data`.
- `out_last`  out  1  registered copy of `req_last` for the held beat.
- `out_ready`  in  1  downstream accepts the held beat.

## Operation

- State machine with two states:
  - IDLE: no owner; grant is chosen each cycle.
  - LOCK: owner fixed, grant held to owner only.
- Grant selection in IDLE: the first requester with `req_valid`=1 searching upward (modulo NREQ) from `rr_ptr`. `rr_ptr` resets to 0.
- Space: `space = ~out_valid | out_ready`.
- `req_ready[g] = space & req_valid[g]`; all other `req_ready` bits are 0.
- Accept = `req_valid[g] & req_ready[g]`. On accept:
  - `out_data`, `out_last` and `out_src` load from g, and `out_valid` is set.
  - If `req_last`=0: go to LOCK with owner=g.
  - If `req_last`=1: stay in or return to IDLE, and set `rr_ptr` = (g+1) mod NREQ.
- In LOCK:
  - Only the owner can be granted. Other requesters are starved until the owner's last beat.
  - An owner deasserting `req_valid` mid-burst holds LOCK and inserts a bubble on the output; no timeout.
  - Accepting the owner's last beat returns to IDLE and advances `rr_ptr` past the owner.
- If `out_ready`=1 with no new accept, `out_valid` clears next cycle.
- `out_data`/`out_src`/`out_last` hold their value while `out_valid`=1 and `out_ready`=0.
- Reset mid-burst:
  - All state clears immediately: IDLE, `rr_ptr`=0, `out_valid`=0.
  - The in-flight burst is dropped, with no partial completion.
- Width rules: data passes bit-for-bit with no transformation. Requester indices ≥ NREQ are never granted.

## Timing

- Reset values:
  - `out_valid`=0, `out_data`=0, `out_src`=0, `out_last`=0.
  - `req_ready`=0 while `rst_n`=0.
  - State IDLE, `rr_ptr`=0.
- `req_ready` is combinational from `req_valid`, state, `rr_ptr`, `out_valid` and `out_ready`. There is no combinational path from `req_data`.
- Latency: a beat accepted in cycle N appears on `out_*` in cycle N+1.
- Throughput: one beat per cycle sustained when `out_ready`=1 continuously.
- Back-to-back handoff: a last beat accepted in cycle N allows a different requester to be accepted in cycle N+1. There is no dead cycle at burst boundaries.
- Simultaneous `out_ready` and accept in the same cycle: the register is replaced and `out_valid` stays 1.

## Configuration

- `IXC_ASSIGN_ARB_STATS_EN`
  - Defined: adds the following ports.
    - `stat_clr`  in  1: synchronous clear of all counters, with priority over increment.
    - `stat_beats`  out  NREQ*16: per-requester 16-bit counters of accepted beats, requester i at [i*16 +: 16]. They saturate at 16'hFFFF and reset to 0.
  - Undefined: these ports and counters are absent, and the arbiter's behaviour is otherwise identical.

## Test plan

- Reset then idle: `rst_n` low for 3 cycles with all `req_valid`=1 → `req_ready`=0 and `out_valid`=0. First release cycle grants requester 0, `out_src`=0 the next cycle.
- Round-robin fairness: all four requesters valid with single beats (`req_last`=1), `out_ready`=1 → `out_src` sequence 0,1,2,3,0,1 on consecutive cycles.
- Burst lock: requester 2 sends 4 beats 38'h0_0000_0001..4 with last on beat 4 while requesters 0/1 are valid → all 4 beats from src 2 appear contiguously, then src 3 (if valid) else 0.
- Backpressure: `out_ready`=0 for 5 cycles with `out_data`=38'h3F_FFFF_FFFF → data, src and last stable, `req_ready` all 0. Releasing `out_ready` gives the next beat one cycle later.
- Reset mid-burst: assert `rst_n` low after beat 2 of a 4-beat burst from requester 1 → `out_valid` drops asynchronously. After release, requester 3 valid alone is granted immediately (no stale lock).
- Stats (`IXC_ASSIGN_ARB_STATS_EN`): 70000 single beats from requester 0 → `stat_beats[15:0]`=16'hFFFF. `stat_clr` pulse concurrent with an accept → counter 0.

Source files
------------

// File: rtl/ixc_assign_arb_38.sv
// Round-robin arbiter with burst lock feeding one registered 38-bit beat to the shared assign datapath.
// Optional per-requester accepted-beat counters are enabled by defining IXC_ASSIGN_ARB_STATS_EN.
module ixc_assign_arb_38 #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 38
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [1:0]        out_src,
    output logic              out_last,
    input  logic              out_ready
`ifdef IXC_ASSIGN_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [NREQ*16-1:0] stat_beats
`endif
);

    typedef enum logic {IDLE, LOCK} state_e;

    state_e       state_q, state_d;
    logic [1:0]   owner_q, owner_d;
    logic [1:0]   rr_ptr_q, rr_ptr_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [1:0]   out_src_q, out_src_d;
    logic         out_last_q, out_last_d;

    logic [3:0]   valid_pad;
    logic [2:0]   sum;
    logic [2:0]   psum;
    logic [1:0]   gnt_idx;
    logic         gnt_hit;
    logic         space;
    logic         accept;
    logic [W-1:0] sel_data;
    logic         sel_last;

    // Grant search works on a 4-bit padded valid so indices >= NREQ read as idle.
    always_comb begin
        valid_pad = 4'(req_valid);
        sum       = '0;
        gnt_hit   = 1'b0;
        gnt_idx   = owner_q;
        if (state_q == LOCK) begin
            gnt_hit = valid_pad[owner_q];
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                sum = {1'b0, rr_ptr_q} + 3'(k);
                if (sum >= 3'(NREQ)) sum = sum - 3'(NREQ);
                if (!gnt_hit && valid_pad[sum[1:0]]) begin
                    gnt_hit = 1'b1;
                    gnt_idx = sum[1:0];
                end
            end
        end
    end

    always_comb begin
        space     = ~out_valid_q | out_ready;
        accept    = rst_n & space & gnt_hit;
        req_ready = '0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == 2'(i)) begin
                sel_data     = req_data[i*W +: W];
                sel_last     = req_last[i];
                req_ready[i] = accept;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        psum        = {1'b0, gnt_idx} + 3'd1;
        if (psum >= 3'(NREQ)) psum = '0;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_src_d   = gnt_idx;
            out_last_d  = sel_last;
            if (sel_last) begin
                state_d  = IDLE;
                rr_ptr_d = psum[1:0];
            end else begin
                state_d = LOCK;
                owner_d = gnt_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef IXC_ASSIGN_ARB_STATS_EN
    logic [15:0] cnt_q [NREQ];
    logic [15:0] cnt_d [NREQ];

    always_comb begin
        stat_beats = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stat_clr) cnt_d[i] = '0;
            else if (accept && gnt_idx == 2'(i) && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 16'd1;
            stat_beats[i*16 +: 16] = cnt_q[i];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
`ifdef IXC_ASSIGN_ARB_STATS_EN
            for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
`ifdef IXC_ASSIGN_ARB_STATS_EN
            for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_ixc_assign_arb_38.sv
// Directed-vector bench for ixc_assign_arb_38: round robin, burst lock, bubbles, backpressure, resets.
module tb_ixc_assign_arb_38;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 38;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [1:0]        out_src;
    logic              out_last;
    logic              out_ready;
`ifdef IXC_ASSIGN_ARB_STATS_EN
    logic              stat_clr;
    logic [NREQ*16-1:0] stat_beats;
`endif

    int errors = 0;
    int checks = 0;

    ixc_assign_arb_38 #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_last(out_last),
        .out_ready(out_ready)
`ifdef IXC_ASSIGN_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_beats(stat_beats)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rv;
        logic [3:0] rl;
        logic       ordy;
        logic [3:0] erdy;
        logic       eov;
        logic [1:0] esrc;
        logic       elast;
        logic [7:0] etag;
    } vec_t;

    vec_t tv [20];

    function automatic logic [37:0] mk(input int unsigned i, input logic [7:0] tag);
        return {2'(i), 4'hC, tag, 24'h5A5A5A};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rv, input logic [3:0] rl, input logic ordy, input logic [7:0] tag);
        req_valid = rv;
        req_last  = rl;
        out_ready = ordy;
        for (int unsigned i = 0; i < NREQ; i++) req_data[i*W +: W] = mk(i, tag);
    endtask

    initial begin
        tv[0]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1, 8'd0};
        tv[1]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 1'b1, 8'd1};
        tv[2]  = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 1'b1, 8'd2};
        tv[3]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 1'b1, 8'd3};
        tv[4]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1, 8'd4};
        tv[5]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 1'b1, 8'd5};
        tv[6]  = '{4'h7, 4'hB, 1'b1, 4'h4, 1'b1, 2'd2, 1'b0, 8'd6};
        tv[7]  = '{4'h7, 4'hB, 1'b1, 4'h4, 1'b1, 2'd2, 1'b0, 8'd7};
        tv[8]  = '{4'h3, 4'hB, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 8'd0};
        tv[9]  = '{4'h7, 4'hB, 1'b1, 4'h4, 1'b1, 2'd2, 1'b0, 8'd9};
        tv[10] = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 1'b1, 8'd10};
        tv[11] = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 1'b1, 8'd11};
        tv[12] = '{4'h1, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 1'b1, 8'd11};
        tv[13] = '{4'h1, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 1'b1, 8'd11};
        tv[14] = '{4'h1, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 1'b1, 8'd11};
        tv[15] = '{4'h1, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1, 8'd15};
        tv[16] = '{4'h0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 1'b1, 8'd15};
        tv[17] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 8'd0};
        tv[18] = '{4'h1, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1, 8'd18};
        tv[19] = '{4'h9, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 1'b1, 8'd19};
`ifdef IXC_ASSIGN_ARB_STATS_EN
        stat_clr = 1'b0;
`endif

        // Reset held 3 cycles with every requester valid.
        rst_n = 1'b0;
        drive(4'hF, 4'hF, 1'b1, 8'hEE);
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            chk("rst_req_ready", 64'(req_ready), 64'h0);
            chk("rst_out_valid", 64'(out_valid), 64'h0);
        end
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_out_src", 64'(out_src), 64'h0);
        chk("rst_out_last", 64'(out_last), 64'h0);
        rst_n = 1'b1;
        #3;
        chk("rel_req_ready", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        chk("rel_out_valid", 64'(out_valid), 64'h1);
        chk("rel_out_src", 64'(out_src), 64'h0);

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;

        for (int n = 0; n < 20; n++) begin
            drive(tv[n].rv, tv[n].rl, tv[n].ordy, 8'(n));
            #3;
            chk($sformatf("v%0d_req_ready", n), 64'(req_ready), 64'(tv[n].erdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d_out_valid", n), 64'(out_valid), 64'(tv[n].eov));
            if (tv[n].eov) begin
                chk($sformatf("v%0d_out_src", n), 64'(out_src), 64'(tv[n].esrc));
                chk($sformatf("v%0d_out_last", n), 64'(out_last), 64'(tv[n].elast));
                chk($sformatf("v%0d_out_data", n), 64'(out_data), 64'(mk(tv[n].esrc, tv[n].etag)));
            end
        end

        // Two beats of a 4-beat burst from requester 1, then reset mid-burst.
        for (int n = 0; n < 2; n++) begin
            drive(4'h2, 4'h0, 1'b1, 8'(8'h40 + n));
            #3;
            chk("burst_req_ready", 64'(req_ready), 64'h2);
            @(posedge clk); #1;
            chk("burst_out_src", 64'(out_src), 64'h1);
            chk("burst_out_data", 64'(out_data), 64'(mk(1, 8'(8'h40 + n))));
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'h0);
        chk("midrst_req_ready", 64'(req_ready), 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(4'h8, 4'h8, 1'b1, 8'h77);
        #3;
        chk("postrst_req_ready", 64'(req_ready), 64'h8);
        @(posedge clk); #1;
        chk("postrst_out_valid", 64'(out_valid), 64'h1);
        chk("postrst_out_src", 64'(out_src), 64'h3);
        chk("postrst_out_data", 64'(out_data), 64'(mk(3, 8'h77)));

`ifdef IXC_ASSIGN_ARB_STATS_EN
        stat_clr = 1'b1;
        drive(4'h0, 4'hF, 1'b1, 8'h00);
        @(posedge clk); #1;
        stat_clr = 1'b0;
        chk("stat_clr_idle", 64'(stat_beats), 64'h0);
        drive(4'h1, 4'hF, 1'b1, 8'h01);
        for (int n = 0; n < 70000; n++) @(posedge clk);
        #1;
        chk("stat_saturate", 64'(stat_beats[15:0]), 64'hFFFF);
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        chk("stat_clr_accept", 64'(stat_beats[15:0]), 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
